coin_return_dispenser: RTL and testbench

- Change-return sequencer for the vending machine: converts a return amount into a sequence of individual coin ejections.
- Drives the coin hopper one coin at a time over a valid/ready handshake.
- Uses greedy largest-coin-first selection, limited by a per-denomination inventory count.
- Sits downstream of the coin/time checker; it is the output end of the coin path whose input end is i_input_coin.

---
 rtl/coin_return_dispenser_if.sv | 40 ++++
 rtl/coin_return_dispenser.sv | 200 ++++++++++++++++++++
 tb/tb_coin_return_dispenser.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coin_return_dispenser_if.sv
// Coin return dispenser bus: return request, hopper handshake, refill pulses,
// and status (busy/done/shortfall/inventory) grouped for one connection.
// Ports: master = requester/hopper side (drives i_*), slave = dispenser (drives o_*).
`ifndef kNumCoins
`define kNumCoins 3
`endif

interface coin_return_dispenser_if #(
  parameter int AMT_W = 32,
  parameter int CNT_W = 8
);
  // request side
  logic                   i_start;
  logic [AMT_W-1:0]       i_amount;
  // hopper handshake
  logic                   i_hopper_ready;
  logic [`kNumCoins-1:0]  o_coin;
  logic                   o_coin_valid;
  // inventory maintenance
  logic [`kNumCoins-1:0]  i_refill;
  // status
  logic                   o_busy;
  logic                   o_done;
  logic [AMT_W-1:0]       o_shortfall;
  logic [CNT_W-1:0]       o_inv0;
  logic [CNT_W-1:0]       o_inv1;
  logic [CNT_W-1:0]       o_inv2;

  modport master (
    output i_start, i_amount, i_hopper_ready, i_refill,
    input  o_coin, o_coin_valid, o_busy, o_done, o_shortfall,
    input  o_inv0, o_inv1, o_inv2
  );

  modport slave (
    input  i_start, i_amount, i_hopper_ready, i_refill,
    output o_coin, o_coin_valid, o_busy, o_done, o_shortfall,
    output o_inv0, o_inv1, o_inv2
  );
endinterface

// File: rtl/coin_return_dispenser.sv
// Change-return sequencer: turns a return amount into one-at-a-time coin
// ejections, greedy largest-coin-first, bounded by per-denomination inventory.
// Ports: clk, reset (async, active-high), bus (coin_return_dispenser_if.slave).
`ifndef kNumCoins
`define kNumCoins 3
`endif

module coin_return_dispenser #(
  parameter int AMT_W     = 32,
  parameter int CNT_W     = 8,
  parameter int INIT_QTY  = 20,
  parameter int COIN0_VAL = 100,
  parameter int COIN1_VAL = 500,
  parameter int COIN2_VAL = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  coin_return_dispenser_if.slave  bus
);

  localparam int NC = `kNumCoins;
  localparam logic [CNT_W-1:0] INV_MAX  = '1;
  localparam logic [CNT_W-1:0] INV_INIT = CNT_W'(INIT_QTY);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPENSE = 2'd1,
    S_DONE     = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [AMT_W-1:0] coin_val [NC];
  logic [CNT_W-1:0] inv      [NC];
  logic [AMT_W-1:0] remaining;
  logic [AMT_W-1:0] shortfall;

  // A coin offered but not yet taken is frozen here so a refill cannot
  // promote a larger denomination under the hopper's feet.
  logic             holding;
  logic [NC-1:0]    held_coin;

  logic [NC-1:0]    fresh_coin;
  logic [AMT_W-1:0] fresh_val;
  logic             fresh_ok;

  logic [NC-1:0]    sel_coin;
  logic             sel_vld;
  logic [AMT_W-1:0] sel_val;

  logic [NC-1:0]    coin;
  logic             coin_vld;
  logic             busy;
  logic             done;
  logic             xfer;
  logic             refill_ok;

  assign coin_val[0] = AMT_W'(COIN0_VAL);
  assign coin_val[1] = AMT_W'(COIN1_VAL);
  assign coin_val[2] = AMT_W'(COIN2_VAL);

  // Greedy candidate: largest-valued denomination that fits the remaining
  // balance and is still in stock. Compares values, so bit order does not
  // have to follow coin value.
  always_comb begin
    fresh_coin = '0;
    fresh_val  = '0;
    fresh_ok   = 1'b0;
    for (int k = 0; k < NC; k++) begin
      if ((inv[k] != '0) && (coin_val[k] <= remaining) &&
          (!fresh_ok || (coin_val[k] > fresh_val))) begin
        fresh_coin    = '0;
        fresh_coin[k] = 1'b1;
        fresh_val     = coin_val[k];
        fresh_ok      = 1'b1;
      end
    end
  end

  assign sel_coin = holding ? held_coin : fresh_coin;
  assign sel_vld  = holding | fresh_ok;

  always_comb begin
    sel_val = '0;
    for (int k = 0; k < NC; k++) begin
      if (sel_coin[k]) begin
        sel_val = sel_val | coin_val[k];
      end
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (bus.i_start) state_nxt = S_DISPENSE;
      S_DISPENSE: if (!sel_vld)    state_nxt = S_DONE;
      S_DONE:                      state_nxt = S_IDLE;
      default:                     state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    coin     = '0;
    coin_vld = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_DISPENSE: begin
        busy = 1'b1;
        if (sel_vld) begin
          coin     = sel_coin;
          coin_vld = 1'b1;
        end
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign xfer      = coin_vld & bus.i_hopper_ready;
  assign refill_ok = $onehot(bus.i_refill);

  // Balance, shortfall and hold tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining <= '0;
      shortfall <= '0;
      holding   <= 1'b0;
      held_coin <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          holding <= 1'b0;
          if (bus.i_start) begin
            remaining <= bus.i_amount;
            shortfall <= '0;
          end
        end
        S_DISPENSE: begin
          if (xfer) begin
            remaining <= remaining - sel_val;
          end
          holding   <= coin_vld & ~bus.i_hopper_ready;
          held_coin <= coin;
          // Capture on the way into DONE so the value is already visible
          // during the o_done cycle; remaining cannot move in this cycle.
          if (!sel_vld) begin
            shortfall <= remaining;
          end
        end
        default: begin
          holding <= 1'b0;
        end
      endcase
    end
  end

  // Inventory: transfer decrements, one-hot refill increments (saturating).
  // Both on the same coin in one cycle cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NC; k++) begin
        inv[k] <= INV_INIT;
      end
    end else begin
      for (int k = 0; k < NC; k++) begin
        if (xfer && coin[k] && !(refill_ok && bus.i_refill[k])) begin
          inv[k] <= inv[k] - 1'b1;
        end else if (refill_ok && bus.i_refill[k] && !(xfer && coin[k]) &&
                     (inv[k] != INV_MAX)) begin
          inv[k] <= inv[k] + 1'b1;
        end
      end
    end
  end

  assign bus.o_coin       = coin;
  assign bus.o_coin_valid = coin_vld;
  assign bus.o_busy       = busy;
  assign bus.o_done       = done;
  assign bus.o_shortfall  = shortfall;
  assign bus.o_inv0       = inv[0];
  assign bus.o_inv1       = inv[1];
  assign bus.o_inv2       = inv[2];

endmodule

// File: tb/tb_coin_return_dispenser.sv
// Bench for coin_return_dispenser: directed and random returns checked
// against a greedy arithmetic model of coins, shortfall and inventory.
// Ports: drives the interface master side; clk/reset generated locally.
module tb_coin_return_dispenser;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  int   val_tab [3] = '{100, 500, 1000};
  int   inv_m   [3];
  int   exp_q   [$];

  coin_return_dispenser_if #(.AMT_W(32), .CNT_W(8)) bus ();

  coin_return_dispenser #(
    .AMT_W(32), .CNT_W(8), .INIT_QTY(20),
    .COIN0_VAL(100), .COIN1_VAL(500), .COIN2_VAL(1000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dut_inv(input int k);
    case (k)
      0:       return bus.o_inv0;
      1:       return bus.o_inv1;
      default: return bus.o_inv2;
    endcase
  endfunction

  // One complete return. mode: 0 ready always, 1 ready pattern 1,0,0,1,
  // 2 random ready, 3 ready low for three cycles then high.
  // poke holds i_start high (with a different amount) while busy.
  task automatic run_return(input int amount, input int mode, input bit poke);
    int rem, n, cyc, last_x;
    bit done_seen, prev_held, rdy;
    logic [2:0] prev_coin, exp_coin;
    exp_q.delete();
    rem = amount;
    for (int k = 2; k >= 0; k--) begin
      n = rem / val_tab[k];
      if (n > inv_m[k]) n = inv_m[k];
      repeat (n) exp_q.push_back(k);
      rem -= n * val_tab[k];
      inv_m[k] -= n;
    end
    bus.i_start  = 1'b1;
    bus.i_amount = amount;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    cyc = 1; last_x = 0; done_seen = 0; prev_held = 0; prev_coin = '0;
    while (!done_seen && cyc < 200) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 4) == 1) || ((cyc % 4) == 0);
        2:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (cyc > 3);
      endcase
      bus.i_hopper_ready = rdy;
      bus.i_start        = poke;
      if (poke) bus.i_amount = 5000;
      @(negedge clk);
      checks++;
      if (bus.o_busy !== 1'b1) begin
        errors++; $display("FAIL ret_busy amt=%0d cyc=%0d got=%0b exp=1", amount, cyc, bus.o_busy);
      end
      if (bus.o_coin_valid === 1'b1) begin
        if (prev_held) begin
          checks++;
          if (bus.o_coin !== prev_coin) begin
            errors++; $display("FAIL ret_hold amt=%0d cyc=%0d got=%b exp=%b", amount, cyc, bus.o_coin, prev_coin);
          end
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL ret_extra_coin amt=%0d cyc=%0d got=%b exp=none", amount, cyc, bus.o_coin);
        end else begin
          exp_coin = 3'b001 << exp_q[0];
          if (bus.o_coin !== exp_coin) begin
            errors++; $display("FAIL ret_coin amt=%0d cyc=%0d got=%b exp=%b", amount, cyc, bus.o_coin, exp_coin);
          end
          if (rdy) begin
            void'(exp_q.pop_front());
            last_x = cyc;
          end
        end
        prev_held = !rdy;
        prev_coin = bus.o_coin;
      end else begin
        prev_held = 0;
        checks++;
        if (bus.o_coin !== 3'b000) begin
          errors++; $display("FAIL ret_coin_idle amt=%0d cyc=%0d got=%b exp=000", amount, cyc, bus.o_coin);
        end
      end
      if (bus.o_done === 1'b1) begin
        done_seen = 1;
        checks++;
        if (cyc != last_x + 2) begin
          errors++; $display("FAIL ret_done_cycle amt=%0d got=%0d exp=%0d", amount, cyc, last_x + 2);
        end
        checks++;
        if (bus.o_shortfall !== 32'(rem)) begin
          errors++; $display("FAIL ret_shortfall amt=%0d got=%0d exp=%0d", amount, bus.o_shortfall, rem);
        end
        checks++;
        if (exp_q.size() != 0) begin
          errors++; $display("FAIL ret_missing_coins amt=%0d got=%0d exp=0", amount, exp_q.size());
        end
      end
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      cyc++;
    end
    bus.i_hopper_ready = 1'b0;
    checks++;
    if (!done_seen) begin
      errors++; $display("FAIL ret_timeout amt=%0d got=no_done exp=done", amount);
    end
    repeat (2) begin
      checks++;
      if (bus.o_busy !== 1'b0 || bus.o_coin_valid !== 1'b0) begin
        errors++; $display("FAIL ret_idle_after amt=%0d got=busy%0b/vld%0b exp=0/0", amount, bus.o_busy, bus.o_coin_valid);
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dut_inv(k) !== 8'(inv_m[k])) begin
        errors++; $display("FAIL ret_inv%0d amt=%0d got=%0d exp=%0d", k, amount, dut_inv(k), inv_m[k]);
      end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (bus.o_coin !== 3'b000 || bus.o_coin_valid !== 1'b0 || bus.o_busy !== 1'b0 ||
        bus.o_done !== 1'b0 || bus.o_shortfall !== 32'd0) begin
      errors++; $display("FAIL reset_outputs got=%b/%b/%b/%b/%0d exp=0", bus.o_coin, bus.o_coin_valid, bus.o_busy, bus.o_done, bus.o_shortfall);
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dut_inv(k) !== 8'd20) begin
        errors++; $display("FAIL reset_inv%0d got=%0d exp=20", k, dut_inv(k));
      end
    end
  endtask

  task automatic test_basic();
    run_return(1700, 0, 0);
    checks++;
    if (bus.o_inv2 !== 8'd19 || bus.o_inv1 !== 8'd19 || bus.o_inv0 !== 8'd18) begin
      errors++; $display("FAIL basic_inv got=%0d/%0d/%0d exp=19/19/18", bus.o_inv2, bus.o_inv1, bus.o_inv0);
    end
  endtask

  task automatic test_toggle_ready();
    run_return(1700, 1, 0);
  endtask

  task automatic test_zero_amount();
    run_return(0, 0, 0);
  endtask

  task automatic test_shortfall_and_ignored_start();
    run_return(150, 3, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      run_return(int'($urandom_range(0, 60)) * 50, 2, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_midflight();
    bit done_seen;
    bus.i_start = 1'b1; bus.i_amount = 3000;
    @(posedge clk); #1;
    bus.i_start = 1'b0; bus.i_hopper_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.o_coin_valid !== 1'b1 || bus.o_coin !== 3'b100) begin
      errors++; $display("FAIL midrst_first_coin got=%b/%b exp=1/100", bus.o_coin_valid, bus.o_coin);
    end
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.o_coin !== 3'b000 || bus.o_coin_valid !== 1'b0 || bus.o_busy !== 1'b0 ||
        bus.o_done !== 1'b0 || bus.o_shortfall !== 32'd0) begin
      errors++; $display("FAIL midrst_outputs got=%b/%b/%b/%b/%0d exp=0", bus.o_coin, bus.o_coin_valid, bus.o_busy, bus.o_done, bus.o_shortfall);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dut_inv(k) !== 8'd20) begin
        errors++; $display("FAIL midrst_inv%0d got=%0d exp=20", k, dut_inv(k));
      end
      inv_m[k] = 20;
    end
    bus.i_hopper_ready = 1'b0;
    @(negedge clk); reset = 1'b0;
    done_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.o_done === 1'b1 || bus.o_busy === 1'b1) done_seen = 1;
    end
    checks++;
    if (done_seen) begin
      errors++; $display("FAIL midrst_no_done got=activity exp=idle");
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 20; i++) run_return(1000, 0, 0);
    checks++;
    if (bus.o_inv2 !== 8'd0) begin
      errors++; $display("FAIL drain_inv2 got=%0d exp=0", bus.o_inv2);
    end
    run_return(1700, 0, 0);
  endtask

  // With 1000 out of stock, offer a 500 and hold it; refilling 1000 while
  // held must not swap the coin on the bus.
  task automatic test_hold_refill();
    int n;
    bus.i_start = 1'b1; bus.i_amount = 1000;
    @(posedge clk); #1;
    bus.i_start = 1'b0; bus.i_hopper_ready = 1'b0; bus.i_refill = 3'b100;
    @(negedge clk);
    checks++;
    if (bus.o_coin_valid !== 1'b1 || bus.o_coin !== 3'b010) begin
      errors++; $display("FAIL hold_first got=%b/%b exp=1/010", bus.o_coin_valid, bus.o_coin);
    end
    @(posedge clk); #1;
    bus.i_refill = 3'b000;
    inv_m[2]++;
    @(negedge clk);
    checks++;
    if (bus.o_coin !== 3'b010 || bus.o_inv2 !== 8'd1) begin
      errors++; $display("FAIL hold_after_refill got=%b inv2=%0d exp=010 inv2=1", bus.o_coin, bus.o_inv2);
    end
    @(posedge clk); #1;
    bus.i_hopper_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.o_coin_valid !== 1'b1 || bus.o_coin !== 3'b010) begin
      errors++; $display("FAIL hold_second got=%b/%b exp=1/010", bus.o_coin_valid, bus.o_coin);
    end
    n = 0;
    while (bus.o_done !== 1'b1 && n < 20) begin
      @(negedge clk); n++;
    end
    checks++;
    if (bus.o_done !== 1'b1 || n != 2 || bus.o_shortfall !== 32'd0) begin
      errors++; $display("FAIL hold_done got=done%0b n=%0d sf=%0d exp=done1 n=2 sf=0", bus.o_done, n, bus.o_shortfall);
    end
    bus.i_hopper_ready = 1'b0;
    inv_m[1] -= 2;
    @(posedge clk); #1;
    checks++;
    if (bus.o_inv1 !== 8'(inv_m[1]) || bus.o_inv2 !== 8'(inv_m[2])) begin
      errors++; $display("FAIL hold_inv got=%0d/%0d exp=%0d/%0d", bus.o_inv1, bus.o_inv2, inv_m[1], inv_m[2]);
    end
  endtask

  task automatic test_refill();
    int n;
    bus.i_start = 1'b1; bus.i_amount = 100;
    @(posedge clk); #1;
    bus.i_start = 1'b0; bus.i_hopper_ready = 1'b1; bus.i_refill = 3'b001;
    @(negedge clk);
    checks++;
    if (bus.o_coin_valid !== 1'b1 || bus.o_coin !== 3'b001) begin
      errors++; $display("FAIL refill_xfer_coin got=%b/%b exp=1/001", bus.o_coin_valid, bus.o_coin);
    end
    @(posedge clk); #1;
    bus.i_refill = 3'b000;
    n = 0;
    while (bus.o_done !== 1'b1 && n < 20) begin
      @(negedge clk); n++;
    end
    bus.i_hopper_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.o_inv0 !== 8'(inv_m[0])) begin
      errors++; $display("FAIL refill_net_zero got=%0d exp=%0d", bus.o_inv0, inv_m[0]);
    end
    bus.i_refill = 3'b011;
    @(posedge clk); #1;
    bus.i_refill = 3'b000;
    checks++;
    if (bus.o_inv0 !== 8'(inv_m[0]) || bus.o_inv1 !== 8'(inv_m[1])) begin
      errors++; $display("FAIL refill_not_onehot got=%0d/%0d exp=%0d/%0d", bus.o_inv0, bus.o_inv1, inv_m[0], inv_m[1]);
    end
    bus.i_refill = 3'b001;
    repeat (300) @(posedge clk);
    #1;
    inv_m[0] = 255;
    checks++;
    if (bus.o_inv0 !== 8'd255) begin
      errors++; $display("FAIL refill_saturate got=%0d exp=255", bus.o_inv0);
    end
    @(posedge clk); #1;
    bus.i_refill = 3'b000;
    checks++;
    if (bus.o_inv0 !== 8'd255) begin
      errors++; $display("FAIL refill_hold_max got=%0d exp=255", bus.o_inv0);
    end
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    checks = 0;
    errors = 0;
    bus.i_start = 1'b0;
    bus.i_amount = '0;
    bus.i_hopper_ready = 1'b0;
    bus.i_refill = '0;
    for (int k = 0; k < 3; k++) inv_m[k] = 20;

    test_reset();
    test_basic();
    test_toggle_ready();
    test_zero_amount();
    test_shortfall_and_ignored_start();
    test_random();
    test_reset_midflight();
    test_drain();
    test_hold_refill();
    test_refill();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
